run_launcher: RTL and testbench

//  Upstream stage of the run/done control FSM. Queues start requests from software/sequencer,

---
 rtl/run_pkg.sv | 19 +
 rtl/run_pend_counter.sv | 33 +++
 rtl/run_launcher.sv | 90 +++++++++
 tb/tb_run_launcher.sv | 302 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/run_pkg.sv
// Shared state encoding and default sizing for the run launcher slice.
// Unreachable encoding 2'b11 is steered back to IDLE by the FSM.
package run_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        LAUNCH = 2'b01,
        WAIT   = 2'b10
    } run_state_t;

    localparam int PEND_W_DEF  = 3;
    localparam int CNT_W_DEF   = 8;
    localparam int TIMEOUT_DEF = 16;

    function automatic logic state_is_busy(input run_state_t s);
        return (s == LAUNCH) || (s == WAIT);
    endfunction

endpackage

// File: rtl/run_pend_counter.sv
// Saturating up/down count of queued requests; 1-cycle update, simultaneous inc/dec nets to zero.
// Increments are ignored when full and decrements when empty, so it never wraps.
module run_pend_counter #(
    parameter int W = 3
) (
    input  logic         i_clock,
    input  logic         i_reset_async_n,
    input  logic         inc,
    input  logic         dec,
    output logic [W-1:0] count,
    output logic         full,
    output logic         empty
);

    logic inc_ok;
    logic dec_ok;

    assign full   = (count == '1);
    assign empty  = (count == '0);
    assign inc_ok = inc && !full;
    assign dec_ok = dec && !empty;

    always_ff @(posedge i_clock or negedge i_reset_async_n) begin
        if (!i_reset_async_n) begin
            count <= '0;
        end else if (inc_ok && !dec_ok) begin
            count <= count + 1'b1;
        end else if (dec_ok && !inc_ok) begin
            count <= count - 1'b1;
        end
    end

endmodule

// File: rtl/run_launcher.sv
// Queues start requests and launches them one at a time as 1-cycle o_run pulses, waiting for i_done.
// Requests back up in the pending counter; o_req_ready drops when it is full and extra requests are dropped.
module run_launcher
    import run_pkg::*;
#(
    parameter int PEND_W  = PEND_W_DEF,
    parameter int CNT_W   = CNT_W_DEF,
    parameter int TIMEOUT = TIMEOUT_DEF
) (
    input  logic              i_clock,
    input  logic              i_reset_async_n,
    input  logic              i_req,
    output logic              o_req_ready,
    input  logic              i_clear,
    output logic              o_run,
    input  logic              i_done,
    output logic              o_busy,
    output logic [PEND_W-1:0] o_pending,
    output logic [CNT_W-1:0]  o_run_count,
    output logic              o_timeout
);

    localparam int TW = $clog2(TIMEOUT);
    localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT - 1);

    run_state_t    state_q;
    run_state_t    state_d;
    logic [TW-1:0] timer_q;
    logic          pend_full;
    logic          pend_empty;
    logic          done_hit;
    logic          expire;

    run_pend_counter #(.W(PEND_W)) u_pend (
        .i_clock         (i_clock),
        .i_reset_async_n (i_reset_async_n),
        .inc             (i_req && o_req_ready),
        .dec             (state_q == LAUNCH),
        .count           (o_pending),
        .full            (pend_full),
        .empty           (pend_empty)
    );

    assign o_req_ready = !pend_full;
    assign o_run       = (state_q == LAUNCH);
    assign o_busy      = state_is_busy(state_q);

    // A done arriving on the final timer cycle completes the run rather than timing out.
    assign done_hit = (state_q == WAIT) && i_done;
    assign expire   = (state_q == WAIT) && !i_done && (timer_q == T_LAST);

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (!pend_empty) state_d = LAUNCH;
            LAUNCH:  state_d = WAIT;
            WAIT:    if (done_hit || expire) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge i_clock or negedge i_reset_async_n) begin
        if (!i_reset_async_n) begin
            state_q <= IDLE;
            timer_q <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == LAUNCH) begin
                timer_q <= '0;
            end else if (state_q == WAIT && !expire) begin
                timer_q <= timer_q + 1'b1;
            end
        end
    end

    // Clear takes priority over a same-cycle completion or timeout.
    always_ff @(posedge i_clock or negedge i_reset_async_n) begin
        if (!i_reset_async_n) begin
            o_run_count <= '0;
            o_timeout   <= 1'b0;
        end else if (i_clear) begin
            o_run_count <= '0;
            o_timeout   <= 1'b0;
        end else begin
            if (done_hit) o_run_count <= o_run_count + 1'b1;
            if (expire)   o_timeout   <= 1'b1;
        end
    end

endmodule

// File: tb/tb_run_launcher.sv
// Directed bench for run_launcher: each task drives one scenario and checks hand-computed values.
module tb_run_launcher;

    logic       i_clock = 1'b0;
    logic       i_reset_async_n = 1'b0;
    logic       i_req = 1'b0;
    logic       o_req_ready;
    logic       i_clear = 1'b0;
    logic       o_run;
    logic       i_done = 1'b0;
    logic       o_busy;
    logic [2:0] o_pending;
    logic [7:0] o_run_count;
    logic       o_timeout;

    int vectors = 0;
    int miscompares = 0;

    run_launcher #(.PEND_W(3), .CNT_W(8), .TIMEOUT(16)) dut (
        .i_clock         (i_clock),
        .i_reset_async_n (i_reset_async_n),
        .i_req           (i_req),
        .o_req_ready     (o_req_ready),
        .i_clear         (i_clear),
        .o_run           (o_run),
        .i_done          (i_done),
        .o_busy          (o_busy),
        .o_pending       (o_pending),
        .o_run_count     (o_run_count),
        .o_timeout       (o_timeout)
    );

    always #5 i_clock = ~i_clock;

    // Advance to 1 time unit after the next rising edge.
    task automatic step();
        @(posedge i_clock);
        #1;
    endtask

    task automatic do_reset();
        i_req = 1'b0;
        i_done = 1'b0;
        i_clear = 1'b0;
        i_reset_async_n = 1'b0;
        step();
        step();
        i_reset_async_n = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        vectors++;
        if ({o_run, o_busy, o_pending, o_run_count, o_timeout, o_req_ready} !== {1'b0, 1'b0, 3'd0, 8'd0, 1'b0, 1'b1}) begin
            miscompares++;
            $display("FAIL reset_values: got run=%b busy=%b pend=%0d cnt=%0d to=%b rdy=%b, want 0 0 0 0 0 1",
                     o_run, o_busy, o_pending, o_run_count, o_timeout, o_req_ready);
        end
    endtask

    task automatic test_single_launch();
        do_reset();
        i_req = 1'b1;
        step();
        i_req = 1'b0;
        vectors++;
        if ({o_run, o_pending} !== {1'b0, 3'd1}) begin
            miscompares++;
            $display("FAIL single_accept: got run=%b pend=%0d, want run=0 pend=1", o_run, o_pending);
        end
        step();
        vectors++;
        if ({o_run, o_busy, o_pending} !== {1'b1, 1'b1, 3'd1}) begin
            miscompares++;
            $display("FAIL single_launch: got run=%b busy=%b pend=%0d, want 1 1 1", o_run, o_busy, o_pending);
        end
        step();
        vectors++;
        if ({o_run, o_busy, o_pending} !== {1'b0, 1'b1, 3'd0}) begin
            miscompares++;
            $display("FAIL single_wait: got run=%b busy=%b pend=%0d, want 0 1 0", o_run, o_busy, o_pending);
        end
    endtask

    // Downstream FSM model: i_done follows each o_run pulse by two cycles.
    task automatic test_back_to_back();
        int   launches = 0;
        int   t_launch[3];
        logic p1 = 1'b0;
        logic p2 = 1'b0;
        logic cur;
        do_reset();
        i_req = 1'b1;
        for (int c = 1; c <= 20; c++) begin
            step();
            i_req = (c < 3);
            cur = o_run;
            if (cur) begin
                if (launches < 3) t_launch[launches] = c;
                launches++;
            end
            i_done = p2;
            p2 = p1;
            p1 = cur;
        end
        i_done = 1'b0;
        vectors++;
        if (launches !== 3) begin
            miscompares++;
            $display("FAIL b2b_launch_count: got %0d, want 3", launches);
        end else begin
            vectors++;
            if (t_launch[0] !== 2 || t_launch[1] !== 6 || t_launch[2] !== 10) begin
                miscompares++;
                $display("FAIL b2b_launch_cycles: got %0d %0d %0d, want 2 6 10", t_launch[0], t_launch[1], t_launch[2]);
            end
        end
        vectors++;
        if ({o_run_count, o_timeout, o_pending, o_busy} !== {8'd3, 1'b0, 3'd0, 1'b0}) begin
            miscompares++;
            $display("FAIL b2b_final: got cnt=%0d to=%b pend=%0d busy=%b, want 3 0 0 0",
                     o_run_count, o_timeout, o_pending, o_busy);
        end
    endtask

    task automatic test_full();
        int peak = 0;
        int runs = 0;
        do_reset();
        i_req = 1'b1;
        for (int c = 1; c <= 10; c++) begin
            step();
            if (c == 10) i_req = 1'b0;
            if (int'(o_pending) > peak) peak = int'(o_pending);
            if (o_run) runs++;
            if (c == 8) begin
                vectors++;
                if ({o_req_ready, o_pending} !== {1'b0, 3'd7}) begin
                    miscompares++;
                    $display("FAIL full_ready: got rdy=%b pend=%0d, want rdy=0 pend=7", o_req_ready, o_pending);
                end
            end
        end
        vectors++;
        if (peak !== 7 || o_pending !== 3'd7) begin
            miscompares++;
            $display("FAIL full_peak: got peak=%0d pend=%0d, want 7 7", peak, o_pending);
        end
        vectors++;
        if (runs !== 1) begin
            miscompares++;
            $display("FAIL full_runs: got %0d launches, want 1", runs);
        end
    endtask

    task automatic test_timeout();
        do_reset();
        i_req = 1'b1;
        step();
        step();
        i_req = 1'b0;
        vectors++;
        if ({o_run, o_pending} !== {1'b1, 3'd2}) begin
            miscompares++;
            $display("FAIL to_launch: got run=%b pend=%0d, want 1 2", o_run, o_pending);
        end
        repeat (16) step();
        vectors++;
        if ({o_busy, o_timeout} !== {1'b1, 1'b0}) begin
            miscompares++;
            $display("FAIL to_last_wait: got busy=%b to=%b, want 1 0", o_busy, o_timeout);
        end
        step();
        vectors++;
        if ({o_timeout, o_busy, o_run} !== {1'b1, 1'b0, 1'b0}) begin
            miscompares++;
            $display("FAIL to_flag: got to=%b busy=%b run=%b, want 1 0 0", o_timeout, o_busy, o_run);
        end
        step();
        vectors++;
        if ({o_run, o_timeout, o_pending} !== {1'b1, 1'b1, 3'd1}) begin
            miscompares++;
            $display("FAIL to_relaunch: got run=%b to=%b pend=%0d, want 1 1 1", o_run, o_timeout, o_pending);
        end
        step();
        i_done = 1'b1;
        step();
        i_done = 1'b0;
        vectors++;
        if ({o_run_count, o_timeout} !== {8'd1, 1'b1}) begin
            miscompares++;
            $display("FAIL to_sticky: got cnt=%0d to=%b, want 1 1", o_run_count, o_timeout);
        end
        i_clear = 1'b1;
        step();
        i_clear = 1'b0;
        vectors++;
        if ({o_run_count, o_timeout} !== {8'd0, 1'b0}) begin
            miscompares++;
            $display("FAIL to_clear: got cnt=%0d to=%b, want 0 0", o_run_count, o_timeout);
        end
    endtask

    task automatic test_done_edges();
        do_reset();
        i_done = 1'b1;
        step();
        i_done = 1'b0;
        vectors++;
        if ({o_run_count, o_busy} !== {8'd0, 1'b0}) begin
            miscompares++;
            $display("FAIL done_idle: got cnt=%0d busy=%b, want 0 0", o_run_count, o_busy);
        end
        i_req = 1'b1;
        step();
        i_req = 1'b0;
        step();
        vectors++;
        if (o_run !== 1'b1) begin
            miscompares++;
            $display("FAIL done_launch: got run=%b, want 1", o_run);
        end
        repeat (16) step();
        vectors++;
        if ({o_busy, o_timeout} !== {1'b1, 1'b0}) begin
            miscompares++;
            $display("FAIL done_pre: got busy=%b to=%b, want 1 0", o_busy, o_timeout);
        end
        i_done = 1'b1;
        step();
        i_done = 1'b0;
        vectors++;
        if ({o_run_count, o_timeout, o_busy} !== {8'd1, 1'b0, 1'b0}) begin
            miscompares++;
            $display("FAIL done_last_cycle: got cnt=%0d to=%b busy=%b, want 1 0 0", o_run_count, o_timeout, o_busy);
        end
        i_req = 1'b1;
        step();
        i_req = 1'b0;
        step();
        step();
        i_done = 1'b1;
        i_clear = 1'b1;
        step();
        i_done = 1'b0;
        i_clear = 1'b0;
        vectors++;
        if ({o_run_count, o_busy} !== {8'd0, 1'b0}) begin
            miscompares++;
            $display("FAIL done_clear_prio: got cnt=%0d busy=%b, want 0 0", o_run_count, o_busy);
        end
    endtask

    task automatic test_reset_mid_run();
        int runs = 0;
        do_reset();
        i_req = 1'b1;
        step();
        step();
        step();
        i_req = 1'b0;
        vectors++;
        if ({o_busy, o_run, o_pending} !== {1'b1, 1'b0, 3'd2}) begin
            miscompares++;
            $display("FAIL rst_setup: got busy=%b run=%b pend=%0d, want 1 0 2", o_busy, o_run, o_pending);
        end
        #2;
        i_reset_async_n = 1'b0;
        #1;
        vectors++;
        if ({o_run, o_busy, o_pending, o_run_count, o_timeout, o_req_ready} !== {1'b0, 1'b0, 3'd0, 8'd0, 1'b0, 1'b1}) begin
            miscompares++;
            $display("FAIL rst_async: got run=%b busy=%b pend=%0d cnt=%0d to=%b rdy=%b, want 0 0 0 0 0 1",
                     o_run, o_busy, o_pending, o_run_count, o_timeout, o_req_ready);
        end
        step();
        step();
        i_reset_async_n = 1'b1;
        for (int c = 0; c < 10; c++) begin
            step();
            if (o_run) runs++;
        end
        vectors++;
        if (runs !== 0 || o_pending !== 3'd0 || o_busy !== 1'b0) begin
            miscompares++;
            $display("FAIL rst_no_run: got runs=%0d pend=%0d busy=%b, want 0 0 0", runs, o_pending, o_busy);
        end
    endtask

    initial begin
        test_reset();
        test_single_launch();
        test_back_to_back();
        test_full();
        test_timeout();
        test_done_edges();
        test_reset_mid_run();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
